muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/div_core.sv | 47 ++++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and helpers for the HI/LO multiply/divide unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set; used for magnitude and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_core.sv
// rtl/div_core.sv - restoring unsigned divider, one shift/subtract step per enabled cycle
module div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // The quotient register doubles as the dividend shifter: its MSB feeds the
    // partial remainder while result bits enter at the LSB.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (en) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - execute-stage multiply/divide unit owning the HI/LO registers
module muldiv_unit #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        rd_hilo,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    import muldiv_pkg::*;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, b_q;
    logic        sgn_q;

    logic        accept;
    logic        op_signed;
    logic        op_is_div;
    logic        dc_load;
    logic        dc_en;
    logic [31:0] dc_quo;
    logic [31:0] dc_rem;
    logic [31:0] a_mag, b_mag;
    logic        q_neg, r_neg;

    logic signed [63:0] mul_a, mul_b, prod;

    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign op_is_div = (op == OP_DIVU) || (op == OP_DIV);
    assign accept    = (state_q == IDLE) && start;

    // Signed divides run on magnitudes; the sign is restored in FIX from the latched raw operands.
    assign a_mag = cond_neg(a_in, op_signed && a_in[31]);
    assign b_mag = cond_neg(b_in, op_signed && b_in[31]);
    assign q_neg = sgn_q && (a_q[31] ^ b_q[31]);
    assign r_neg = sgn_q && a_q[31];

    // Extending to 64 bits before multiplying gives the exact product for both signednesses.
    assign mul_a = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign mul_b = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign prod  = mul_a * mul_b;

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (dc_load),
        .en        (dc_en),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (dc_quo),
        .remainder (dc_rem)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if (accept) begin
                a_q   <= a_in;
                b_q   <= b_in;
                sgn_q <= op_signed;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dc_load = 1'b0;
        dc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // start outranks a same-cycle MTHI/MTLO, whose write is dropped.
                    dc_load = op_is_div;
                    state_d = op_is_div ? DIV : MUL;
                    cnt_d   = op_is_div ? 5'(DIV_ITERS - 1) : 5'(MUL_CYCLES - 1);
                end else begin
                    if (wr_hi) hi_d = a_in;
                    if (wr_lo) lo_d = a_in;
                end
            end
            MUL: begin
                if (cnt_q == 5'd0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DIV: begin
                dc_en = 1'b1;
                if (cnt_q == 5'd0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            FIX: begin
                state_d = IDLE;
                if (b_q == 32'd0) begin
                    hi_d = a_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = cond_neg(dc_rem, r_neg);
                    lo_d = cond_neg(dc_quo, q_neg);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst && (state_q == IDLE) && start) begin
            assert (!(wr_hi || wr_lo));
        end
    end

    assign busy      = (state_q != IDLE);
    assign stall_req = busy && (start || rd_hilo || wr_hi || wr_lo);
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;

    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        wr_hi = 1'b0;
    logic        wr_lo = 1'b0;
    logic        rd_hilo = 1'b0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_hilo = '0;

    muldiv_unit #(.MUL_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .a_in      (a_in),
        .b_in      (b_in),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .rd_hilo   (rd_hilo),
        .busy      (busy),
        .stall_req (stall_req),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        int sq, sr;
        case (o)
            2'b00: return {32'd0, a} * {32'd0, b};
            2'b01: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                return sa * sb;
            end
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {sr, sq};
            end
        endcase
    endfunction

    task automatic drive_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o;
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] want, input int lat);
        int n;
        logic [63:0] e;
        exp_q.push_back(want);
        drive_start(o, a, b);
        check({tag, " busy"}, 64'(busy), 64'd1);
        check({tag, " hold"}, {hi_out, lo_out}, last_hilo);
        wait_done(n);
        check({tag, " latency"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        check({tag, " hilo"}, {hi_out, lo_out}, e);
        last_hilo = e;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [63:0] e;
        logic [31:0] ra, rb;

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset hilo", {hi_out, lo_out}, 64'd0);
        check("reset stall", 64'(stall_req), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        run_op("mult neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 4);
        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 4);
        run_op("div neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op("divu by zero", OP_DIVU, 32'h1234_5678, 32'd0, {32'h1234_5678, 32'hFFFF_FFFF}, 33);
        run_op("div overflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        run_op("div by zero neg", OP_DIV, 32'h8765_4321, 32'd0, {32'h8765_4321, 32'hFFFF_FFFF}, 33);
        run_op("div rem neg", OP_DIV, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op($sformatf("rand op%0d", i), 2'(i), ra, rb, model(2'(i), ra, rb), (i < 2) ? 4 : 33);
        end

        // Dependent MFHI/MFLO and a second divide stalled behind an in-flight divide.
        exp_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFF2});
        drive_start(OP_DIV, 32'hFFFF_FF9C, 32'd7);
        for (int k = 1; k <= 33; k++) begin
            if (k == 3) rd_hilo = 1'b1;
            if (k == 5) begin
                op = OP_DIVU;
                a_in = 32'd100;
                b_in = 32'd7;
                start = 1'b1;
            end
            #1;
            check($sformatf("stall c%0d", k), 64'(stall_req), (k >= 3) ? 64'd1 : 64'd0);
            check($sformatf("old hilo c%0d", k), {hi_out, lo_out}, last_hilo);
            @(posedge clk);
            #1;
        end
        check("stall busy fell", 64'(busy), 64'd0);
        check("stall released", 64'(stall_req), 64'd0);
        e = exp_q.pop_front();
        check("stall div hilo", {hi_out, lo_out}, e);
        last_hilo = e;
        rd_hilo = 1'b0;
        exp_q.push_back({32'd2, 32'd14});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held start accepted", 64'(busy), 64'd1);
        wait_done(n);
        check("held start latency", 64'(n), 64'd33);
        e = exp_q.pop_front();
        check("held start hilo", {hi_out, lo_out}, e);
        last_hilo = e;

        // Reset in the middle of a multiply aborts it without a write.
        drive_start(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi_out, lo_out}, 64'd0);
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("abort no late write", {hi_out, lo_out}, 64'd0);
        rd_hilo = 1'b1;
        #1;
        check("idle no stall", 64'(stall_req), 64'd0);
        rd_hilo = 1'b0;

        a_in = 32'hCAFE_F00D;
        wr_lo = 1'b1;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo", {hi_out, lo_out}, {32'd0, 32'hCAFE_F00D});
        a_in = 32'h1357_9BDF;
        wr_hi = 1'b1;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        check("mthi", {hi_out, lo_out}, {32'h1357_9BDF, 32'hCAFE_F00D});
        last_hilo = {32'h1357_9BDF, 32'hCAFE_F00D};

        // MTHI while busy is stalled and must not disturb the pending result.
        exp_q.push_back({32'd0, 32'd12});
        drive_start(OP_MULTU, 32'd3, 32'd4);
        a_in = 32'hDEAD_BEEF;
        wr_hi = 1'b1;
        #1;
        check("mthi busy stall", 64'(stall_req), 64'd1);
        wait_done(n);
        check("mthi busy latency", 64'(n), 64'd4);
        e = exp_q.pop_front();
        check("mthi busy ignored", {hi_out, lo_out}, e);
        wr_hi = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
